// File: rtl/uart_pkg.sv
// uart_pkg: receiver state codes, default line rates and baud divisor helpers
package uart_pkg;
    localparam int CLK_FREQ_DEF = 50_000_000;
    localparam int BAUD_DEF     = 9600;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction
    function automatic int half_div(input int clk_freq, input int baud);
        return baud_div(clk_freq, baud) / 2;
    endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: 2-flop synchronizer plus falling-edge detector for the serial line
// ports: i_clk, i_rst_n (async active-low), i_rx raw line; o_rx synchronized line, o_fall one-cycle falling edge
module uart_rx_sync (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_rx,
    output logic o_rx,
    output logic o_fall
);
    logic [2:0] r_sh;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_sh <= 3'b111;
        else          r_sh <= {r_sh[1:0], i_rx};
    end
    assign o_rx   = r_sh[1];
    assign o_fall = r_sh[2] & ~r_sh[1];
endmodule

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8-bit UART receiver, LSB first, optional even parity when UART_RX_PARITY_EN is defined
// ports: i_clk, i_rst_n (async active-low), i_uart_rx serial line (idle high);
//        o_rx_data last good byte, o_rx_valid/o_frame_err/o_parity_err one-cycle pulses, o_busy not idle
module uart_byte_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_uart_rx,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_frame_err,
    output logic       o_parity_err,
    output logic       o_busy
);
    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int HALF_DIV = half_div(CLK_FREQ, BAUD);
    localparam int CW = $clog2(BAUD_DIV) > 13 ? $clog2(BAUD_DIV) : 13;
    localparam logic [CW-1:0] C_HALF = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] C_FULL = CW'(BAUD_DIV - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_AFTER_DATA = ST_PARITY;
`else
    localparam logic [2:0] ST_AFTER_DATA = ST_STOP;
`endif
    logic          w_rx;
    logic          w_fall;
    logic          w_tick;
    logic          w_perr;
    logic [2:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_err;
    uart_rx_sync u_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_rx   (i_uart_rx),
        .o_rx   (w_rx),
        .o_fall (w_fall)
    );
    // START samples at half a bit to land mid-bit; every later sample is one full bit on
    assign w_tick = r_cnt == (r_state == ST_START ? C_HALF : C_FULL);
`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_parity_err;
    assign w_perr       = r_perr;
    assign o_parity_err = r_parity_err;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_perr       <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_parity_err <= r_state == ST_STOP && w_tick && w_rx && r_perr;
            if (r_state == ST_START) r_perr <= 1'b0;
            else if (r_state == ST_PARITY && w_tick) r_perr <= w_rx != ^r_shift;
        end
    end
`else
    assign w_perr       = 1'b0;
    assign o_parity_err = 1'b0;
`endif
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit       <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_cnt <= (r_state == ST_IDLE || r_state == ST_WAIT_HIGH || w_tick) ? '0 : r_cnt + 1'b1;
            case (r_state)
                ST_IDLE:      if (w_fall) r_state <= ST_START;
                ST_START:     if (w_tick) r_state <= w_rx ? ST_IDLE : ST_DATA;
                ST_DATA: if (w_tick) begin
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 1'b1;
                    if (r_bit == 3'd7) r_state <= ST_AFTER_DATA;
                end
                ST_PARITY:    if (w_tick) r_state <= ST_STOP;
                ST_STOP: if (w_tick) begin
                    r_state     <= w_rx ? ST_IDLE : ST_WAIT_HIGH;
                    r_frame_err <= !w_rx;
                    r_rx_valid  <= w_rx && !w_perr;
                    if (w_rx && !w_perr) r_rx_data <= r_shift;
                end
                ST_WAIT_HIGH: if (w_rx) r_state <= ST_IDLE;
                default:      r_state <= ST_IDLE;
            endcase
        end
    end
    assign o_rx_data   = r_rx_data;
    assign o_rx_valid  = r_rx_valid;
    assign o_frame_err = r_frame_err;
    assign o_busy      = r_state != ST_IDLE;
endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: randomized frame stimulus checked against an event-queue model of the receiver
module tb_uart_byte_rx;
    localparam int CF   = 1_600_000;
    localparam int BR   = 100_000;
    localparam int DIV  = CF / BR;
    localparam int HALF = DIV / 2;
    localparam int TOL  = 4;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int NB = PAR ? 11 : 10;
    typedef struct {
        logic [2:0] kind;
        logic [7:0] data;
        int         t;
    } ev_t;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       parity_err;
    logic       busy;
    int         cyc    = 0;
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] last_good = 8'h00;
    logic [2:0] pulses;
    ev_t        ev;
    ev_t        exp_q[$];
    uart_byte_rx #(.CLK_FREQ(CF), .BAUD(BR)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_uart_rx   (rx),
        .o_rx_data   (rx_data),
        .o_rx_valid  (rx_valid),
        .o_frame_err (frame_err),
        .o_parity_err(parity_err),
        .o_busy      (busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask
    task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
        n_chk++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
        end
    endtask
    // pulse kinds: 100 = byte received, 010 = framing error, 001 = parity error
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {rx_data, rx_valid, frame_err, parity_err, busy}, 32'h0);
            last_good = 8'h00;
        end else begin
            pulses = {rx_valid, frame_err, parity_err};
            chk("pulse_exclusive", 32'($countones(pulses) <= 1), 32'd1);
            if (pulses != 3'b000) begin
                if (exp_q.size() == 0) chk("unexpected_pulse", {29'd0, pulses}, 32'd0);
                else begin
                    ev = exp_q.pop_front();
                    chk("pulse_kind", {29'd0, pulses}, {29'd0, ev.kind});
                    chk_rng("pulse_latency", cyc, ev.t - TOL, ev.t + TOL);
                    if (ev.kind == 3'b100) begin
                        chk("rx_data_new", {24'd0, rx_data}, {24'd0, ev.data});
                        last_good = ev.data;
                    end else chk("rx_data_kept", {24'd0, rx_data}, {24'd0, last_good});
                end
            end else begin
                chk("rx_data_hold", {24'd0, rx_data}, {24'd0, last_good});
                if (exp_q.size() != 0 && cyc > exp_q[0].t + TOL) begin
                    ev = exp_q.pop_front();
                    chk("missing_pulse", 32'd0, {29'd0, ev.kind});
                end
            end
        end
    end
    task automatic bit_time(input logic b);
        rx = b;
        repeat (DIV) @(negedge clk);
    endtask
    task automatic idle(input int nbits);
        rx = 1'b1;
        repeat (nbits * DIV) @(negedge clk);
    endtask
    // stop_low > 0 sends that many low bit times from the stop bit on and leaves the line low
    task automatic send(input logic [7:0] d, input int stop_low, input logic par_flip);
        ev_t e;
        e.t    = cyc + HALF + (NB - 1) * DIV;
        e.data = d;
        e.kind = stop_low > 0 ? 3'b010 : (PAR && par_flip) ? 3'b001 : 3'b100;
        exp_q.push_back(e);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        if (PAR) bit_time((^d) ^ par_flip);
        if (stop_low > 0) repeat (stop_low) bit_time(1'b0);
        else bit_time(1'b1);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    initial begin
        int d, r, sl, gl;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", {24'd0, rx_data}, 32'h00);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h55, 0, 1'b0);
        idle(2);
        chk("data_55", {24'd0, rx_data}, 32'h55);
        chk("busy_after_55", {31'd0, busy}, 32'd0);
        send(8'hA3, 0, 1'b0);
        chk("data_a3", {24'd0, rx_data}, 32'hA3);
        send(8'h0F, 0, 1'b0);
        idle(2);
        chk("data_0f", {24'd0, rx_data}, 32'h0F);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch_busy", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        repeat (HALF + 4) @(negedge clk);
        chk("glitch_busy_clear", {31'd0, busy}, 32'd0);
        chk("glitch_data", {24'd0, rx_data}, 32'h0F);
        idle(1);
        send(8'h3C, 21, 1'b0);
        chk("break_busy", {31'd0, busy}, 32'd1);
        chk("break_data", {24'd0, rx_data}, 32'h0F);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        chk("break_busy_clear", {31'd0, busy}, 32'd0);
        idle(2);
        bit_time(1'b0);
        for (int i = 0; i < 4; i++) bit_time(1'b1);
        repeat (HALF) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;
        repeat (4) bit_time(1'b1);
        idle(1);
        chk("abort_data", {24'd0, rx_data}, 32'h00);
        send(8'h81, 0, 1'b0);
        idle(2);
        chk("data_81", {24'd0, rx_data}, 32'h81);
`ifdef UART_RX_PARITY_EN
        send(8'h07, 0, 1'b1);
        idle(2);
        chk("bad_parity_data", {24'd0, rx_data}, 32'h81);
        send(8'h07, 0, 1'b0);
        idle(2);
        chk("good_parity_data", {24'd0, rx_data}, 32'h07);
`endif
        for (int n = 0; n < 30; n++) begin
            d  = int'($urandom_range(0, 255));
            r  = int'($urandom_range(0, 9));
            sl = r == 0 ? int'($urandom_range(1, 4)) : 0;
            if (r == 2) begin
                gl = int'($urandom_range(1, HALF - 3));
                rx = 1'b0;
                repeat (gl) @(negedge clk);
                idle(1);
            end
            send(8'(d), sl, PAR && r == 1);
            if (sl > 0) idle(1);
            else idle(int'($urandom_range(0, 1)));
        end
        idle(3);
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_byte_rx.md
UART_BYTE_RX -- requirements
Module: uart_byte_rx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, line bit rate.
REQ-003 Derived constant BAUD_DIV = CLK_FREQ/BAUD (5208 at defaults); HALF_DIV = BAUD_DIV/2 (2604).
REQ-004 Clk  input  1  system clock; all logic on posedge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 uart_rx  input  1  asynchronous serial line; idle high.
REQ-007 rx_data  output  8  last correctly received byte, LSB first on line.
REQ-008 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-009 frame_err  output  1  one-cycle pulse when the stop bit samples low.
REQ-010 parity_err  output  1  one-cycle pulse on parity mismatch; constant 0 when parity is compiled out.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 uart_rx shall pass through a 2-flop synchronizer; all decisions use the synchronized value, giving 2 cycles of input latency.
REQ-013 States: IDLE, START, DATA, PARITY (only when parity is enabled), STOP, WAIT_HIGH.
REQ-014 IDLE -> START on a synchronized high-to-low transition; the baud counter is cleared on that cycle.
REQ-015 START: at count HALF_DIV-1, sample; low -> DATA with counter cleared; high -> IDLE with no output pulse (glitch rejection).
REQ-016 DATA: sample each bit at count BAUD_DIV-1 (mid-bit); shift into bit 7 of the shift register, LSB first; after the 8th sample go to PARITY or STOP.
REQ-017 PARITY: sample at BAUD_DIV-1; a mismatch with even parity over the 8 data bits sets an internal error flag.
REQ-018 STOP: sample at BAUD_DIV-1; on high with no parity error, load rx_data and pulse rx_valid on the next cycle, then go to IDLE.
REQ-019 STOP sampled high with a parity error: pulse parity_err, leave rx_data unchanged, go to IDLE.
REQ-020 STOP sampled low: pulse frame_err, leave rx_data unchanged, go to WAIT_HIGH.
REQ-021 WAIT_HIGH: stay until the synchronized line is high, then go to IDLE; this covers break conditions.
REQ-022 The baud counter is 13 bits minimum, wraps to 0 at each sample point, and is held at 0 in IDLE and WAIT_HIGH.
REQ-023 Back-to-back frames: a start edge arriving in the cycle after the STOP-to-IDLE transition shall be accepted.
REQ-024 rx_valid, frame_err and parity_err are mutually exclusive and never asserted for more than one cycle.

Reset
REQ-025 Reset_n low shall asynchronously force: state IDLE, counters 0, shift register 0, rx_data 8'h00, all pulse outputs and busy 0, synchronizer flops 1.
REQ-026 A reset asserted mid-frame shall abort the frame with no output pulse; after release the receiver waits for a fresh falling edge.

Configuration
REQ-027 Macro UART_RX_PARITY_EN: when defined, one even-parity bit is expected between data and stop (11-bit frame); when undefined, the PARITY state and logic are absent, the frame is 10 bits, and parity_err is tied to 0.

Structure
REQ-028 Package uart_pkg shall hold the state enumeration, the default CLK_FREQ/BAUD constants and the BAUD_DIV/HALF_DIV computation.
REQ-029 Sub-module uart_rx_sync shall contain the 2-flop synchronizer and falling-edge detector; everything else stays in uart_byte_rx.

Verification
REQ-030 Frame 0x55 at 9600 baud (defaults) -> rx_data=8'h55, rx_valid one pulse about 9.5 bit times (49,476 ±4 cycles) after the start edge.
REQ-031 Frames 0xA3 then 0x0F with no idle gap -> two rx_valid pulses; rx_data=8'hA3, then 8'h0F.
REQ-032 Line low for 1000 cycles, then high -> no pulse on any output; busy returns to 0 after HALF_DIV cycles.
REQ-033 Frame 0x3C with the stop bit held low, then 20 further bit times low -> one frame_err pulse, rx_data unchanged, busy high until the line rises.
REQ-034 Reset_n pulsed low during bit 4 of 0xFF, then frame 0x81 -> only 8'h81 received.
REQ-035 With UART_RX_PARITY_EN: 0x07 sent with parity bit 0 -> one parity_err pulse, no rx_valid; sent with parity bit 1 -> rx_valid with rx_data=8'h07.
